// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-to-arithmetic-unit sequencer for a two-operand calculator.
// Ports: clock, reset (async high); key_code/key_valid in, key_ready out;
//        result in from the AU; x_bus, load_a/load_b/load_r/clear_au, add_sub out;
//        disp_sel (0 entry, 1 result) and err (sticky entry overflow) out.
module calc_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic [7:0] result,
    output logic       key_ready,
    output logic [7:0] x_bus,
    output logic       load_a,
    output logic       load_b,
    output logic       load_r,
    output logic       clear_au,
    output logic       add_sub,
    output logic       disp_sel,
    output logic       err
);
    typedef enum logic [2:0] {
        ENTER_A,
        OP_WAIT,
        ENTER_B,
        EXEC_B,
        EXEC_W,
        EXEC_R,
        SHOW
    } state_t;

    state_t      state;
    logic [7:0]  entry;
    logic [7:0]  res_q;
    logic [1:0]  count;
    logic        chain;
    logic        pend;
    logic        xres;
    logic        fresh;

    logic        busy;
    logic        chain_go;
    logic        accept;
    logic        is_dig;
    logic        is_op;
    logic        is_ce;
    logic        is_ca;
    logic        is_eq;
    logic [11:0] prod;
    logic        dig_ok;
    logic [7:0]  acc_entry;
    logic [1:0]  acc_count;
    logic        acc_err;
    logic [7:0]  res_view;

    always_comb begin
        busy      = (state == EXEC_B) || (state == EXEC_W) ||
                    (state == EXEC_R);
        // The automatic chained load_a owns the first SHOW cycle,
        // so no key is taken while it happens.
        chain_go  = (state == SHOW) && chain;
        key_ready = !busy && !chain_go;
        accept    = key_valid && key_ready;
        is_dig    = accept && (key_code <= 4'd9);
        is_op     = accept && ((key_code == 4'hA) ||
                               (key_code == 4'hB));
        is_ce     = accept && (key_code == 4'hC);
        is_ca     = accept && (key_code == 4'hD);
        is_eq     = accept && (key_code == 4'hE);
        prod      = ({4'h0, entry} * 12'd10) + {8'h00, key_code};
        dig_ok    = (count != 2'd3) && (prod <= 12'd255);
        acc_entry = dig_ok ? prod[7:0] : entry;
        acc_count = dig_ok ? count + 2'd1 : count;
        acc_err   = err | ~dig_ok;
        // result is valid in the first SHOW cycle but is only
        // captured at its end, so bypass it for that cycle.
        res_view  = fresh ? result : res_q;
        if ((state == SHOW) || ((state == OP_WAIT) && xres))
            x_bus = res_view;
        else
            x_bus = entry;
        load_a    = chain_go ||
                    (is_op && ((state == ENTER_A) || (state == SHOW)));
        load_b    = (state == EXEC_B);
        load_r    = (state == EXEC_R);
        clear_au  = is_ca;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ENTER_A;
            entry    <= 8'h00;
            count    <= 2'd0;
            res_q    <= 8'h00;
            chain    <= 1'b0;
            pend     <= 1'b0;
            xres     <= 1'b0;
            fresh    <= 1'b0;
            add_sub  <= 1'b0;
            disp_sel <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (fresh) begin
                res_q <= result;
                fresh <= 1'b0;
            end
            if (is_ca) begin
                state    <= ENTER_A;
                entry    <= 8'h00;
                count    <= 2'd0;
                res_q    <= 8'h00;
                chain    <= 1'b0;
                pend     <= 1'b0;
                xres     <= 1'b0;
                fresh    <= 1'b0;
                add_sub  <= 1'b0;
                disp_sel <= 1'b0;
                err      <= 1'b0;
            end else if (is_ce) begin
                entry <= 8'h00;
                count <= 2'd0;
                err   <= 1'b0;
            end else begin
                unique case (state)
                    ENTER_A: begin
                        if (is_dig) begin
                            entry <= acc_entry;
                            count <= acc_count;
                            err   <= acc_err;
                        end else if (is_op) begin
                            add_sub <= key_code[0];
                            entry   <= 8'h00;
                            count   <= 2'd0;
                            xres    <= 1'b0;
                            state   <= OP_WAIT;
                        end
                    end
                    OP_WAIT: begin
                        if (is_dig) begin
                            entry    <= acc_entry;
                            count    <= acc_count;
                            err      <= acc_err;
                            disp_sel <= 1'b0;
                            xres     <= 1'b0;
                            state    <= ENTER_B;
                        end else if (is_op) begin
                            add_sub <= key_code[0];
                        end
                    end
                    ENTER_B: begin
                        if (is_dig) begin
                            entry <= acc_entry;
                            count <= acc_count;
                            err   <= acc_err;
                        end else if (is_eq) begin
                            state <= EXEC_B;
                        end else if (is_op) begin
                            pend  <= key_code[0];
                            chain <= 1'b1;
                            state <= EXEC_B;
                        end
                    end
                    EXEC_B: state <= EXEC_W;
                    EXEC_W: state <= EXEC_R;
                    EXEC_R: begin
                        state    <= SHOW;
                        disp_sel <= 1'b1;
                        fresh    <= 1'b1;
                    end
                    SHOW: begin
                        if (chain) begin
                            add_sub <= pend;
                            chain   <= 1'b0;
                            entry   <= 8'h00;
                            count   <= 2'd0;
                            xres    <= 1'b1;
                            state   <= OP_WAIT;
                        end else if (is_dig) begin
                            entry    <= {4'h0, key_code};
                            count    <= 2'd1;
                            disp_sel <= 1'b0;
                            state    <= ENTER_A;
                        end else if (is_op) begin
                            add_sub <= key_code[0];
                            entry   <= 8'h00;
                            count   <= 2'd0;
                            xres    <= 1'b1;
                            state   <= OP_WAIT;
                        end
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end
endmodule
